// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ requesters,
// sequencing write/busy/done and keeping sticky frame/timeout error flags.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                      baud_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      tx_enable_o,
    output logic                      tx_write_o,
    output logic [DATA_W-1:0]         tx_data_o,
    input  logic                      tx_busy_i,
    input  logic                      tx_done_i,
    input  logic                      tx_error_i,
    output logic                      idle_o,
    output logic                      frame_err_o,
    output logic                      timeout_err_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d, own_q, own_d, pick, nxt;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d, grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                write_q, write_d, fe_q, fe_d, te_q, te_d, en_q;
    logic                found, expired;

    // Descending scan so the nearest set request at or after ptr wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                pick  = PW'((int'(ptr_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign nxt     = PW'((int'(own_q) + 1) % NUM_REQ);
    assign expired = timer_q == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        timer_d = timer_q;
        ack_d   = '0;
        grant_d = grant_q;
        write_d = write_q;
        data_d  = data_q;
        fe_d    = fe_q;
        te_d    = te_q;
        if (!enable_i) begin
            state_d = IDLE;
            write_d = 1'b0;
            grant_d = '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    own_d   = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    data_d  = req_data_i[int'(pick)*DATA_W +: DATA_W];
                    write_d = 1'b1;
                    timer_d = '0;
                    state_d = ISSUE;
                end
                ISSUE, WAIT_DONE: begin
                    timer_d = timer_q + TW'(1);
                    // Completion beats timeout; busy alone is not completion.
                    if ((state_q == WAIT_DONE && tx_done_i) || expired) begin
                        ack_d   = grant_q;
                        grant_d = '0;
                        write_d = 1'b0;
                        ptr_d   = nxt;
                        state_d = IDLE;
                        fe_d    = fe_q | (state_q == WAIT_DONE && tx_done_i && tx_error_i);
                        te_d    = te_q | !(state_q == WAIT_DONE && tx_done_i);
                    end else if (state_q == ISSUE && tx_busy_i) begin
                        write_d = 1'b0;
                        state_d = WAIT_DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge baud_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            timer_q <= '0;
            ack_q   <= '0;
            grant_q <= '0;
            write_q <= 1'b0;
            data_q  <= '0;
            fe_q    <= 1'b0;
            te_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            write_q <= write_d;
            data_q  <= data_d;
            fe_q    <= fe_d;
            te_q    <= te_d;
            en_q    <= enable_i;
        end
    end

    assign ack_o         = ack_q;
    assign grant_o       = grant_q;
    assign tx_enable_o   = en_q;
    assign tx_write_o    = write_q;
    assign tx_data_o     = data_q;
    assign idle_o        = state_q == IDLE;
    assign frame_err_o   = fe_q;
    assign timeout_err_o = te_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, directed corner sequences and randomized
// traffic checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int N = 4, W = 8, TO = 32;

    logic           baud_i = 1'b0, reset_i = 1'b1, enable_i = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic           tx_busy_i = 1'b0, tx_done_i = 1'b0, tx_error_i = 1'b0;
    logic [N-1:0]   ack_o, grant_o;
    logic           tx_enable_o, tx_write_o, idle_o, frame_err_o, timeout_err_o;
    logic [W-1:0]   tx_data_o;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .baud_i(baud_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
        .req_data_i(req_data_i), .ack_o(ack_o), .grant_o(grant_o),
        .tx_enable_o(tx_enable_o), .tx_write_o(tx_write_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .tx_error_i(tx_error_i),
        .idle_o(idle_o), .frame_err_o(frame_err_o), .timeout_err_o(timeout_err_o));

    always #5 baud_i = ~baud_i;

    int checks = 0, failures = 0;
    int u_st = 0, u_cnt = 0, frames = 0;
    bit stuck = 0, hold = 0, err_next = 0, noise = 0, u_err = 0, done_err = 0;
    logic [7:0] last_byte = '0;

    typedef struct { logic [3:0] req; bit err; logic [3:0] gnt; bit ferr; } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: accepts a write when idle, raises busy after 0..2 cycles,
    // then pulses done (with optional error) as busy falls.
    task automatic cyc();
        @(negedge baud_i);
        if (u_st == 2) chk("write_while_busy", 32'(tx_write_o), 0);
        tx_done_i  = 1'b0;
        tx_error_i = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        case (u_st)
            0: if (tx_write_o && tx_enable_o && !stuck) begin
                u_st = 1; u_cnt = $urandom_range(0, 2); last_byte = tx_data_o;
                u_err = err_next | (noise && $urandom_range(0, 5) == 0); err_next = 0; frames++;
            end
            1: if (u_cnt == 0) begin tx_busy_i = 1'b1; u_st = 2; u_cnt = $urandom_range(1, 6); end
               else u_cnt--;
            default: if (!hold) begin
                if (u_cnt == 0) begin
                    tx_busy_i = 1'b0; tx_done_i = 1'b1; tx_error_i = u_err; done_err = u_err; u_st = 0;
                end else u_cnt--;
            end
        endcase
    endtask

    task automatic u_reset();
        u_st = 0; hold = 0; tx_busy_i = 1'b0; tx_done_i = 1'b0; tx_error_i = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input int k, input int i);
        return 8'(8'h11 * (i + 1) + k);
    endfunction

    function automatic int oh2i(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_data(input int k);
        for (int i = 0; i < N; i++) req_data_i[i*W +: W] = byte_of(k, i);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, 32'(ack_o), 0);
        chk({tag, "_grant"}, 32'(grant_o), 0);
        chk({tag, "_tx_enable"}, 32'(tx_enable_o), 0);
        chk({tag, "_tx_write"}, 32'(tx_write_o), 0);
        chk({tag, "_tx_data"}, 32'(tx_data_o), 0);
        chk({tag, "_idle"}, 32'(idle_o), 1);
        chk({tag, "_frame_err"}, 32'(frame_err_o), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err_o), 0);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        cyc();
        while (grant_o == '0 && n < 40) begin cyc(); n++; end
        if (grant_o == '0) chk({tag, "_grant_wait_expired"}, 0, 1);
    endtask

    task automatic xact(input logic [3:0] r, input bit e, input logic [3:0] g, input bit ferr,
                        input logic [7:0] b, input string tag);
        int n = 0, f0;
        f0 = frames; req_i = r; err_next = e;
        wait_grant(tag);
        chk({tag, "_grant"}, 32'(grant_o), 32'(g));
        chk({tag, "_tx_data"}, 32'(tx_data_o), 32'(b));
        chk({tag, "_tx_write"}, 32'(tx_write_o), 1);
        cyc();
        while (ack_o == '0 && n < 80) begin cyc(); n++; end
        chk({tag, "_ack"}, 32'(ack_o), 32'(g));
        chk({tag, "_line_byte"}, 32'(last_byte), 32'(b));
        chk({tag, "_frame_err"}, 32'(frame_err_o), 32'(ferr));
        chk({tag, "_grant_cleared"}, 32'(grant_o), 0);
        chk({tag, "_frames"}, 32'(frames - f0), 1);
        req_i = '0;
        cyc();
        chk({tag, "_ack_one_cycle"}, 32'(ack_o), 0);
        chk({tag, "_idle"}, 32'(idle_o), 1);
    endtask

    initial begin
        int n, wc, f0, m_ptr, owner, exp, nacks;
        bit active, m_ferr;
        logic [N-1:0] req_prev;
        logic [7:0] bytes[N];
        tbl[0]  = '{4'b0010, 0, 4'b0010, 0};
        tbl[1]  = '{4'b0011, 0, 4'b0001, 0};
        tbl[2]  = '{4'b1111, 0, 4'b0010, 0};
        tbl[3]  = '{4'b1111, 0, 4'b0100, 0};
        tbl[4]  = '{4'b1111, 0, 4'b1000, 0};
        tbl[5]  = '{4'b1111, 0, 4'b0001, 0};
        tbl[6]  = '{4'b1001, 0, 4'b1000, 0};
        tbl[7]  = '{4'b0001, 1, 4'b0001, 1};
        tbl[8]  = '{4'b0110, 0, 4'b0010, 1};
        tbl[9]  = '{4'b0110, 0, 4'b0100, 1};
        tbl[10] = '{4'b0011, 0, 4'b0001, 1};
        repeat (3) @(negedge baud_i);
        chk_reset("reset");
        reset_i = 1'b0; enable_i = 1'b1;

        for (int k = 0; k < 11; k++) begin
            set_data(k);
            xact(tbl[k].req, tbl[k].err, tbl[k].gnt, tbl[k].ferr,
                 byte_of(k, oh2i(tbl[k].gnt)), $sformatf("vec%0d", k));
        end

        // Stuck transmitter: owner dropped after TIMEOUT_CYC cycles of tx_write.
        stuck = 1; req_i = 4'b0100; set_data(12);
        wait_grant("to");
        chk("to_grant", 32'(grant_o), 32'b0100);
        wc = int'(tx_write_o); n = 0;
        cyc();
        while (ack_o == '0 && n < 60) begin wc += int'(tx_write_o); n++; cyc(); end
        chk("to_write_cycles", 32'(wc), TO);
        chk("to_ack", 32'(ack_o), 32'b0100);
        chk("to_timeout_err", 32'(timeout_err_o), 1);
        chk("to_tx_write", 32'(tx_write_o), 0);
        chk("to_grant_cleared", 32'(grant_o), 0);
        req_i = '0; stuck = 0;
        cyc();
        set_data(13);
        xact(4'b0001, 0, 4'b0001, 1, byte_of(13, 0), "after_to");
        chk("after_to_timeout_err", 32'(timeout_err_o), 1);

        // Disable during WAIT_DONE, then the aborted owner is served from the kept ptr.
        hold = 1; req_i = 4'b1001; set_data(14);
        wait_grant("dis");
        chk("dis_grant", 32'(grant_o), 32'b1000);
        n = 0;
        while (tx_write_o && n < 20) begin cyc(); n++; end
        enable_i = 1'b0;
        cyc();
        chk("dis_grant0", 32'(grant_o), 0);
        chk("dis_tx_enable", 32'(tx_enable_o), 0);
        chk("dis_ack", 32'(ack_o), 0);
        chk("dis_idle", 32'(idle_o), 1);
        u_reset();
        cyc(); cyc();
        chk("dis_hold_grant", 32'(grant_o), 0);
        enable_i = 1'b1;
        xact(4'b1001, 0, 4'b1000, 1, byte_of(14, 3), "reen");
        chk("reen_tx_enable", 32'(tx_enable_o), 1);

        // Asynchronous reset between edges mid-frame.
        req_i = 4'b0100; set_data(15);
        wait_grant("ar");
        chk("ar_grant", 32'(grant_o), 32'b0100);
        #2 reset_i = 1'b1;
        #1 chk_reset("async");
        u_reset(); req_i = '0;
        @(negedge baud_i);
        reset_i = 1'b0;
        set_data(16);
        xact(4'b1000, 0, 4'b1000, 0, byte_of(16, 3), "post_reset");

        // Randomized traffic against a round-robin transaction model.
        noise = 1; m_ptr = 0; m_ferr = 0; active = 0; owner = 0; nacks = 0;
        f0 = frames; req_i = '0; req_prev = '0;
        for (int i = 0; i < N; i++) bytes[i] = '0;
        for (int c = 0; c < 3100; c++) begin
            cyc();
            if (!active) begin
                chk("rnd_spurious_ack", 32'(ack_o), 0);
                if (req_prev != '0) begin
                    exp = rr(req_prev, m_ptr);
                    chk("rnd_grant", 32'(grant_o), 32'(1) << exp);
                    chk("rnd_data", 32'(tx_data_o), 32'(bytes[exp]));
                    owner = exp; active = 1;
                end else chk("rnd_nogrant", 32'(grant_o), 0);
            end else if (ack_o != '0) begin
                chk("rnd_ack", 32'(ack_o), 32'(1) << owner);
                chk("rnd_line_byte", 32'(last_byte), 32'(bytes[owner]));
                m_ferr |= done_err;
                chk("rnd_frame_err", 32'(frame_err_o), 32'(m_ferr));
                m_ptr = (owner + 1) % N; active = 0; req_i[owner] = 1'b0; nacks++;
            end
            if (c < 3000) begin
                for (int i = 0; i < N; i++)
                    if (!req_i[i] && !(active && i == owner) && $urandom_range(0, 3) == 0) begin
                        bytes[i] = 8'($urandom); req_i[i] = 1'b1; req_data_i[i*W +: W] = bytes[i];
                    end
                if (active && $urandom_range(0, 7) == 0) req_data_i[owner*W +: W] = 8'($urandom);
                if (active && $urandom_range(0, 15) == 0) req_i[owner] = 1'b0;
            end
            req_prev = req_i;
        end
        chk("rnd_drained", 32'(active), 0);
        chk("rnd_progress", 32'(nacks > 100), 1);
        chk("rnd_frames", 32'(frames - f0), 32'(nacks));
        chk("rnd_timeout_err", 32'(timeout_err_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ requesters with round-robin arbitration. Sequences the transmitter's write/busy/done handshake and latches the winning requester's byte. Returns a one-cycle ack per completed frame and keeps sticky error flags for frame errors and lost handshakes. Sits between the monitor's byte producers and uart_tx, in the baud clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data bits per frame; must equal NUM_DATA_BITS of the attached transmitter
TIMEOUT_CYC, 32, baud cycles allowed per frame before the owner is dropped

Ports:
baud  in  1  baud clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
enable  in  1  global enable; low forces IDLE and drops tx_enable
req  in  NUM_REQ  per-requester request; held with data stable until ack
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse to owner when its frame completes or is dropped
grant  out  NUM_REQ  one-hot current owner; all zero in IDLE
tx_enable  out  1  to uart_tx enable; registered copy of enable
tx_write  out  1  to uart_tx write
tx_data  out  DATA_W  to uart_tx data; latched owner byte
tx_busy  in  1  from uart_tx busy
tx_done  in  1  from uart_tx done
tx_error  in  1  from uart_tx error
idle  out  1  high in IDLE state
frame_err  out  1  sticky; set when tx_error is high in the same cycle as tx_done
timeout_err  out  1  sticky; set on timeout

Behaviour:
- Reset values: ack=0, grant=0, tx_enable=0, tx_write=0, tx_data=0, idle=1, frame_err=0, timeout_err=0. Internal values: ptr=0, state=IDLE, timer=0.
- All outputs are registered. Sticky flags clear only on reset.
- States are IDLE, ISSUE and WAIT_DONE.
- IDLE:
  - If enable is high and any req is high, pick the first set req at or after ptr, searching upward with wrap.
  - Set grant to that requester, tx_data to its req_data and tx_write=1. Clear timer and go to ISSUE.
  - The request is accepted on the edge where it is sampled; the next transfer starts at the earliest 1 cycle after the prior ack.
- ISSUE:
  - Hold tx_write=1 until tx_busy=1 is sampled.
  - Then drop tx_write to 0 and go to WAIT_DONE.
  - tx_write must never be high while the transmitter is back in idle after the frame; this prevents a duplicate frame.
- WAIT_DONE:
  - On tx_done=1, pulse ack[owner] for one cycle and clear grant.
  - Set ptr to (owner+1) mod NUM_REQ and go to IDLE.
  - If tx_error is high in the same cycle, also set frame_err.
- Timer:
  - Increments every cycle in ISSUE and WAIT_DONE.
  - When timer reaches TIMEOUT_CYC-1 without completion: set timeout_err, pulse ack[owner], clear tx_write and grant, advance ptr and go to IDLE.
  - The timer is wide enough for TIMEOUT_CYC with no wrap.
- enable low in any state:
  - Next edge: state goes to IDLE, tx_write=0, grant=0, tx_enable=0, no ack. ptr and sticky flags are kept.
  - The aborted owner's req stays pending and is re-arbitrated from the unchanged ptr once enable returns high.
- req[i] dropping before ack: the frame still completes because data is latched. ack is still pulsed to i.
- req_data changes after grant: ignored.
- Simultaneous tx_done and timeout in the same cycle: tx_done wins and timeout_err is not set.
- Round robin: the owner gets the lowest priority next. With all req high, grants cycle 0,1,2,3,0...

Test Plan:
- Single request: req=0010, req_data[1]=8'hA5, healthy uart_tx model -> grant=0010; tx_write high until busy; uart line carries A5 LSB-first with parity; ack=0010 for exactly 1 cycle; ptr=2; frame_err=0.
- Fairness: req=1111 held, bytes 11,22,33,44, ack each in turn -> transmit order 11,22,33,44,11; no gap longer than 1 idle cycle between frames.
- Error frame: tx_model asserts error with done on a 8'h3C frame from req 0 -> ack[0] pulses; frame_err=1 and stays 1 through 3 further clean frames.
- Timeout: stuck model (busy never high), TIMEOUT_CYC=32, req=0100 -> tx_write dropped after 32 cycles; ack[2] pulses; timeout_err=1; next req=0001 is served normally.
- Mid-frame disable: enable low during WAIT_DONE of req 3 -> next edge grant=0, tx_enable=0, no ack; re-enable -> req 3 is re-granted first.
- Async reset mid-frame: assert reset between edges -> all outputs at reset values immediately; after release, req=1000 -> grant=1000, since ptr=0 and only req 3 is pending.
